pixel_bus_writer: RTL and testbench

Host-side driver for the parallel pixel-load bus of the VGA framebuffer FPGA: a 15-bit address, 3-bit RGB and a write strobe whose rising edge commits one pixel. Takes single-pixel or whole-frame fill requests over a valid/ready handshake. Converts (x, y) to a linear 200x150 framebuffer address and emits each write with programmable setup/strobe/hold phases so the receiver samples stable address and data.

---
 rtl/pixel_bus_pkg.sv | 20 ++
 rtl/pixel_addr_calc.sv | 28 ++
 rtl/pixel_bus_writer.sv | 153 +++++++++++++++
 tb/tb_pixel_bus_writer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_bus_pkg.sv
// Shared constants and FSM encoding for the VGA framebuffer pixel-load bus writer.
package pixel_bus_pkg;

  localparam int H_RES    = 200;
  localparam int V_RES    = 150;
  localparam int FB_DEPTH = 30000;
  localparam int ADDR_W   = 15;

  localparam int RGB_R = 0;
  localparam int RGB_G = 1;
  localparam int RGB_B = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/pixel_addr_calc.sv
// Combinational (x, y) range check, shift-add linear address and fill-address stepping.
module pixel_addr_calc
  import pixel_bus_pkg::*;
(
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic [ADDR_W-1:0] cur_addr,
  output logic              in_range,
  output logic [ADDR_W-1:0] xy_addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              cur_last
);

  logic [ADDR_W-1:0] x_w;
  logic [ADDR_W-1:0] y_w;

  assign x_w = ADDR_W'(x);
  assign y_w = ADDR_W'(y);

  assign in_range = (x < 8'(H_RES)) && (y < 8'(V_RES));

  // y*200 = y*128 + y*64 + y*8; only meaningful when in_range, so truncation is harmless.
  assign xy_addr = x_w + (y_w << 7) + (y_w << 6) + (y_w << 3);

  assign next_addr = cur_addr + ADDR_W'(1);
  assign cur_last  = (cur_addr == ADDR_W'(FB_DEPTH - 1));

endmodule

// File: rtl/pixel_bus_writer.sv
// Drives the framebuffer pixel-load bus with setup/strobe/hold phases for single-pixel or full-frame fill requests.
module pixel_bus_writer
  import pixel_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_fill,
  input  logic [7:0]          req_x,
  input  logic [7:0]          req_y,
  input  logic [2:0]          req_rgb,
  output logic                req_drop,
  output logic                busy,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [2:0]          bus_rgb,
  output logic                bus_strobe
);

  localparam int MAX_P = (SETUP_CYCLES > STROBE_CYCLES)
                         ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                         : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CNT_W = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          rgb_q, rgb_d;
  logic                fill_q, fill_d;
  logic                strobe_q, strobe_d;
  logic                drop_q, drop_d;

  logic                xy_in_range;
  logic [ADDR_W-1:0]   xy_addr;
  logic [ADDR_W-1:0]   next_addr;
  logic                addr_last;

  pixel_addr_calc u_addr_calc (
    .x         (req_x),
    .y         (req_y),
    .cur_addr  (addr_q),
    .in_range  (xy_in_range),
    .xy_addr   (xy_addr),
    .next_addr (next_addr),
    .cur_last  (addr_last)
  );

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rgb_d    = rgb_q;
    fill_d   = fill_q;
    strobe_d = 1'b0;
    drop_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_fill) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LOAD;
            addr_d  = '0;
            rgb_d   = req_rgb;
            fill_d  = 1'b1;
          end else if (xy_in_range) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LOAD;
            addr_d  = xy_addr;
            rgb_d   = req_rgb;
            fill_d  = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d  = ST_STROBE;
          cnt_d    = STROBE_LOAD;
          strobe_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          strobe_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (fill_q && !addr_last) begin
          // Next fill pixel starts immediately: no idle gap between pixels.
          state_d = ST_SETUP;
          cnt_d   = SETUP_LOAD;
          addr_d  = next_addr;
        end else begin
          state_d = ST_IDLE;
          fill_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rgb_q    <= '0;
      fill_q   <= 1'b0;
      strobe_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rgb_q    <= rgb_d;
      fill_q   <= fill_d;
      strobe_q <= strobe_d;
      drop_q   <= drop_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign bus_addr   = addr_q;
  assign bus_rgb    = rgb_q;
  assign bus_strobe = strobe_q;
  assign req_drop   = drop_q;

endmodule

// File: tb/tb_pixel_bus_writer.sv
// Scoreboard bench: default-timing instance for single pixels/reset, 1/1/1 instance for a full-frame fill.
module tb_pixel_bus_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Instance 0: default timing 2/2/1
  logic        rn0, valid0, ready0, fill0, drop0, busy0, st0;
  logic [7:0]  x0, y0;
  logic [2:0]  rgb0, brgb0;
  logic [14:0] addr0;

  pixel_bus_writer dut0 (
    .CLK(clk), .RESETN(rn0), .req_valid(valid0), .req_ready(ready0), .req_fill(fill0),
    .req_x(x0), .req_y(y0), .req_rgb(rgb0), .req_drop(drop0), .busy(busy0),
    .bus_addr(addr0), .bus_rgb(brgb0), .bus_strobe(st0)
  );

  // Instance 1: fast timing 1/1/1
  logic        rn1, valid1, ready1, fill1, drop1, busy1, st1;
  logic [7:0]  x1, y1;
  logic [2:0]  rgb1, brgb1;
  logic [14:0] addr1;

  pixel_bus_writer #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) dut1 (
    .CLK(clk), .RESETN(rn1), .req_valid(valid1), .req_ready(ready1), .req_fill(fill1),
    .req_x(x1), .req_y(y1), .req_rgb(rgb1), .req_drop(drop1), .busy(busy1),
    .bus_addr(addr1), .bus_rgb(brgb1), .bus_strobe(st1)
  );

  logic [17:0] q0[$];
  logic [17:0] q1[$];
  int rises[2];

  // Bus monitor: scoreboard on strobe rise plus setup/strobe/hold phase checks.
  int S_P[2] = '{2, 1};
  int T_P[2] = '{2, 1};
  int H_P[2] = '{1, 1};
  logic [17:0] prev_ar[2];
  logic        prev_st[2];
  int          stable[2];
  int          low[2];
  int          high[2];
  logic [17:0] cur_ar, exp_ar;
  logic        cur_st, cur_rn, have;

  initial begin
    rises = '{0, 0};
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        cur_ar = (i == 0) ? {addr0, brgb0} : {addr1, brgb1};
        cur_st = (i == 0) ? st0 : st1;
        cur_rn = (i == 0) ? rn0 : rn1;
        if (!cur_rn) begin
          prev_ar[i] = '0; prev_st[i] = 1'b0;
          stable[i] = 100; low[i] = 100; high[i] = 0;
        end else begin
          if (cur_ar != prev_ar[i]) begin
            check($sformatf("chg_while_strobe%0d", i), {31'd0, cur_st | prev_st[i]}, 32'd0);
            check($sformatf("hold_len%0d", i), {31'd0, low[i] >= H_P[i]}, 32'd1);
            stable[i] = 0;
          end
          if (cur_st && !prev_st[i]) begin
            check($sformatf("setup_len%0d", i), {31'd0, stable[i] >= S_P[i]}, 32'd1);
            have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
            check($sformatf("sb_pending%0d", i), {31'd0, have}, 32'd1);
            if (have) begin
              exp_ar = (i == 0) ? q0.pop_front() : q1.pop_front();
              check($sformatf("sb_addr%0d", i), {17'd0, cur_ar[17:3]}, {17'd0, exp_ar[17:3]});
              check($sformatf("sb_rgb%0d", i), {29'd0, cur_ar[2:0]}, {29'd0, exp_ar[2:0]});
            end
            rises[i]++;
            high[i] = 0;
          end
          if (!cur_st && prev_st[i]) begin
            check($sformatf("strobe_len%0d", i), high[i], T_P[i]);
            low[i] = 0;
          end
          if (cur_st) high[i]++; else low[i]++;
          stable[i]++;
          prev_ar[i] = cur_ar;
          prev_st[i] = cur_st;
        end
      end
    end
  end

  task automatic drive0(input logic f, input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    valid0 = 1'b1; fill0 = f; x0 = x; y0 = y; rgb0 = c;
    @(posedge clk);
    @(negedge clk);
    valid0 = 1'b0;
  endtask

  task automatic wait_idle0(input string tag);
    int g;
    g = 0;
    while (!ready0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check(tag, {31'd0, ready0}, 32'd1);
  endtask

  logic done0 = 1'b0;
  logic done1 = 1'b0;

  // Instance 0 sequence
  initial begin
    logic exp_st[6];
    int   r_save;
    int   g;
    exp_st = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    rn0 = 1'b0; valid0 = 1'b0; fill0 = 1'b0; x0 = '0; y0 = '0; rgb0 = '0;
    repeat (3) @(negedge clk);
    check("rst_addr", {17'd0, addr0}, 32'd0);
    check("rst_rgb", {29'd0, brgb0}, 32'd0);
    check("rst_strobe", {31'd0, st0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_drop", {31'd0, drop0}, 32'd0);
    check("rst_ready", {31'd0, ready0}, 32'd1);
    rn0 = 1'b1;
    @(negedge clk);

    // Single pixel (3,2): address 403, phase timeline after accept edge
    q0.push_back({15'd403, 3'b101});
    drive0(1'b0, 8'd3, 8'd2, 3'b101);
    check("p1_addr", {17'd0, addr0}, 32'd403);
    check("p1_rgb", {29'd0, brgb0}, 32'd5);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("p1_strobe_e%0d", k), {31'd0, st0}, {31'd0, exp_st[k]});
      check($sformatf("p1_ready_e%0d", k), {31'd0, ready0}, (k == 5) ? 32'd1 : 32'd0);
      if (k < 5) @(negedge clk);
    end

    // Last in-range pixel
    q0.push_back({15'd29999, 3'b010});
    drive0(1'b0, 8'd199, 8'd149, 3'b010);
    check("p2_addr", {17'd0, addr0}, 32'd29999);
    wait_idle0("p2_idle");
    @(negedge clk);

    // Out-of-range requests are dropped, bus untouched
    r_save = rises[0];
    for (int k = 0; k < 2; k++) begin
      drive0(1'b0, (k == 0) ? 8'd200 : 8'd0, (k == 0) ? 8'd0 : 8'd150, 3'b111);
      check($sformatf("drop%0d_pulse", k), {31'd0, drop0}, 32'd1);
      check($sformatf("drop%0d_ready", k), {31'd0, ready0}, 32'd1);
      @(negedge clk);
      check($sformatf("drop%0d_clear", k), {31'd0, drop0}, 32'd0);
      check($sformatf("drop%0d_busy", k), {31'd0, busy0}, 32'd0);
    end
    repeat (5) @(negedge clk);
    check("drop_addr_kept", {17'd0, addr0}, 32'd29999);
    check("drop_no_strobe", rises[0], r_save);

    // req_valid held through busy with changing x: second request waits for IDLE
    q0.push_back({15'd5, 3'b001});
    q0.push_back({15'd7, 3'b001});
    valid0 = 1'b1; fill0 = 1'b0; x0 = 8'd5; y0 = 8'd0; rgb0 = 3'b001;
    @(posedge clk);
    @(negedge clk);
    check("hv_first_addr", {17'd0, addr0}, 32'd5);
    x0 = 8'd7;
    repeat (5) @(negedge clk);
    check("hv_idle_ready", {31'd0, ready0}, 32'd1);
    check("hv_idle_addr", {17'd0, addr0}, 32'd5);
    @(negedge clk);
    check("hv_second_addr", {17'd0, addr0}, 32'd7);
    check("hv_second_busy", {31'd0, busy0}, 32'd1);
    valid0 = 1'b0;
    wait_idle0("hv_idle2");
    @(negedge clk);

    // Fill interrupted by reset while pixel 1000 is strobing
    for (int a = 0; a <= 1000; a++) q0.push_back({15'(a), 3'b110});
    drive0(1'b1, 8'd77, 8'd88, 3'b110);
    g = 0;
    while (!(addr0 == 15'd1000 && st0) && g < 10000) begin
      @(negedge clk);
      g++;
    end
    check("fr_reach_1000", {31'd0, (addr0 == 15'd1000) && st0}, 32'd1);
    #1 rn0 = 1'b0;
    #1;
    check("fr_rst_strobe", {31'd0, st0}, 32'd0);
    check("fr_rst_addr", {17'd0, addr0}, 32'd0);
    check("fr_rst_rgb", {29'd0, brgb0}, 32'd0);
    check("fr_rst_busy", {31'd0, busy0}, 32'd0);
    check("fr_rst_ready", {31'd0, ready0}, 32'd1);
    r_save = rises[0];
    repeat (2) @(negedge clk);
    rn0 = 1'b1;
    repeat (30) @(negedge clk);
    check("fr_no_resume", rises[0], r_save);
    check("fr_idle", {31'd0, ready0}, 32'd1);
    check("fr_sb_empty", q0.size(), 32'd0);
    done0 = 1'b1;
  end

  // Instance 1: full-frame fill with 3-cycle pixel period
  initial begin
    int busy_cnt;
    int r_save;
    rn1 = 1'b0; valid1 = 1'b0; fill1 = 1'b0; x1 = '0; y1 = '0; rgb1 = '0;
    repeat (3) @(negedge clk);
    check("f_rst_ready", {31'd0, ready1}, 32'd1);
    rn1 = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 30000; a++) q1.push_back({15'(a), 3'b111});
    valid1 = 1'b1; fill1 = 1'b1; x1 = 8'd250; y1 = 8'd250; rgb1 = 3'b111;
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0;
    busy_cnt = 0;
    while (busy1 && busy_cnt < 95000) begin
      busy_cnt++;
      @(negedge clk);
    end
    check("f_busy_cycles", busy_cnt, 32'd90000);
    check("f_rises", rises[1], 32'd30000);
    check("f_sb_empty", q1.size(), 32'd0);
    check("f_last_addr", {17'd0, addr1}, 32'd29999);
    r_save = rises[1];
    repeat (20) @(negedge clk);
    check("f_no_wrap", rises[1], r_save);
    check("f_idle_ready", {31'd0, ready1}, 32'd1);
    done1 = 1'b1;
  end

  initial begin
    wait (done0 && done1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
